stim_gen: RTL and testbench

STIM_GEN -- requirements
Module: stim_gen

---
 rtl/stim_gen_if.sv | 29 ++
 rtl/stim_gen.sv | 188 ++++++++++++++++++
 tb/tb_stim_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stim_gen_if.sv
// Beat output channel of the stimulus generator: valid/ready handshake
// carrying one address/data pair per accepted beat.
interface stim_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    // Producer side: presents beats, observes back-pressure
    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    // Consumer side: receives beats, drives back-pressure
    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/stim_gen.sv
// Stimulus generator: emits a run of address/data beats on a valid/ready
// channel. Address advances by a fixed step per accepted beat; data follows
// one of four patterns (increment, decrement, Galois LFSR, constant).
// A run ends after 'count' beats (0 = endless) or on 'stop'.
module stim_gen #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ADDR_STEP  = 1,
    parameter int                    DATA_STEP  = 1,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(32'h8020_0003),
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(1)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    input  logic [DATA_WIDTH-1:0] data_base,
    stim_gen_if.master            out_if,
    output logic [ADDR_WIDTH-1:0] beat_cnt,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_INC   = 2'd0,
        M_DEC   = 2'd1,
        M_LFSR  = 2'd2,
        M_CONST = 2'd3
    } mode_e;

    localparam logic [ADDR_WIDTH-1:0] ASTEP = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [DATA_WIDTH-1:0] DSTEP = DATA_WIDTH'(DATA_STEP);
    localparam logic [ADDR_WIDTH-1:0] AONE  = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    mode_e                 mode_q,  mode_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  valid_q, valid_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] cnt_inc;

    // One Galois shift: LSB falls out; if it was set, fold the polynomial in
    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_POLY;
        end
        return r;
    endfunction

    // Data word following 'd' for the selected pattern
    function automatic logic [DATA_WIDTH-1:0] next_data(input mode_e m,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (m)
            M_INC:   r = d + DSTEP;
            M_DEC:   r = d - DSTEP;
            M_LFSR:  r = lfsr_step(d);
            default: r = d;
        endcase
        return r;
    endfunction

    // First data word of a run; an all-zero LFSR state would lock up, so seed it
    function automatic logic [DATA_WIDTH-1:0] first_data(input mode_e m,
                                                         input logic [DATA_WIDTH-1:0] base);
        logic [DATA_WIDTH-1:0] r;
        r = base;
        if (m == M_LFSR && base == '0) begin
            r = LFSR_SEED;
        end
        return r;
    endfunction

    assign accept  = valid_q && out_if.out_ready;
    assign cnt_inc = cnt_q + AONE;

    // Next-state and registered-output logic for the IDLE/RUN/DONE controller
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // stop outranks start; a DONE run otherwise stays frozen
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode_e'(mode);
                    count_d = count;
                    addr_d  = addr_base;
                    data_d  = first_data(mode_e'(mode), data_base);
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end

            S_RUN: begin
                // An accepted beat always advances, even on the edge that stops
                if (accept) begin
                    addr_d = addr_q + ASTEP;
                    data_d = next_data(mode_q, data_q);
                    cnt_d  = cnt_inc;
                end
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (accept && count_q != '0 && cnt_inc == count_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the run immediately
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_INC;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_data  = data_q;
    assign beat_cnt         = cnt_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: fixed vectors with hand-computed expectations.
module tb_stim_gen;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] count;
    logic [31:0] addr_base;
    logic [31:0] data_base;
    logic [31:0] beat_cnt;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    stim_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    stim_gen #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ADDR_STEP  (1),
        .DATA_STEP  (1),
        .LFSR_POLY  (32'h8020_0003),
        .LFSR_SEED  (32'h1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .count     (count),
        .addr_base (addr_base),
        .data_base (data_base),
        .out_if    (bus),
        .beat_cnt  (beat_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic kick(input logic [1:0] m, input logic [31:0] c,
                        input logic [31:0] ab, input logic [31:0] db);
        mode = m; count = c; addr_base = ab; data_base = db; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start = 0; stop = 0; mode = 0; count = 0; addr_base = 0; data_base = 0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_addr", bus.out_addr, 0);
        chk("rst_data", bus.out_data, 0);
        sys_rst_n = 1'b1;
        step();
        chk("idle_valid", bus.out_valid, 0);

        // INC, 4 beats, always ready
        kick(2'd0, 32'd4, 32'd0, 32'd0);
        chk("inc_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("inc_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("inc_addr%0d", i), bus.out_addr, i);
            chk($sformatf("inc_data%0d", i), bus.out_data, i);
            step();
        end
        chk("inc_done", done, 1);
        chk("inc_valid_end", bus.out_valid, 0);
        chk("inc_busy_end", busy, 0);
        chk("inc_cnt", beat_cnt, 4);
        step();
        chk("inc_frozen_cnt", beat_cnt, 4);
        chk("inc_frozen_done", done, 1);

        // DEC from 1, restart straight out of DONE
        kick(2'd1, 32'd3, 32'd0, 32'd1);
        chk("dec_data0", bus.out_data, 32'h1);
        step();
        chk("dec_data1", bus.out_data, 32'h0);
        step();
        chk("dec_data2", bus.out_data, 32'hFFFF_FFFF);
        step();
        chk("dec_done", done, 1);
        chk("dec_cnt", beat_cnt, 3);

        // Back-pressure at beat 2
        kick(2'd0, 32'd5, 32'd10, 32'd100);
        step();
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("stall_addr%0d", i), bus.out_addr, 12);
            chk($sformatf("stall_data%0d", i), bus.out_data, 102);
            chk($sformatf("stall_cnt%0d", i), beat_cnt, 2);
        end
        bus.out_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            chk($sformatf("resume_addr%0d", i), bus.out_addr, 10 + i);
            chk($sformatf("resume_data%0d", i), bus.out_data, 100 + i);
            step();
        end
        chk("stall_done", done, 1);
        chk("stall_cnt_end", beat_cnt, 5);

        // LFSR from zero base: seed substituted
        kick(2'd2, 32'd2, 32'd0, 32'd0);
        chk("lfsr_data0", bus.out_data, 32'h1);
        step();
        chk("lfsr_data1", bus.out_data, 32'h8020_0003);
        step();
        chk("lfsr_done", done, 1);

        // stop out of DONE
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("done_stop_done", done, 0);
        chk("done_stop_busy", busy, 0);

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("both_idle_busy", busy, 0);
        chk("both_idle_valid", bus.out_valid, 0);

        // Endless run across address wrap
        kick(2'd3, 32'd0, 32'hFFFF_FFFE, 32'h5);
        chk("wrap_addr0", bus.out_addr, 32'hFFFF_FFFE);
        step();
        chk("wrap_addr1", bus.out_addr, 32'hFFFF_FFFF);
        // start with new config while running must be ignored
        start = 1'b1; addr_base = 32'h777; mode = 2'd0;
        step();
        start = 1'b0;
        chk("wrap_addr2", bus.out_addr, 32'h0);
        chk("wrap_const", bus.out_data, 32'h5);
        step();
        chk("wrap_addr3", bus.out_addr, 32'h1);
        chk("wrap_busy", busy, 1);
        step();
        chk("wrap_cnt4", beat_cnt, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_cnt", beat_cnt, 5);
        chk("stop_busy", busy, 0);
        chk("stop_valid", bus.out_valid, 0);
        chk("stop_done", done, 0);

        // Reset pulse mid-run
        kick(2'd0, 32'd0, 32'h40, 32'h0);
        step();
        step();
        chk("pre_rst_addr", bus.out_addr, 32'h42);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_cnt", beat_cnt, 0);
        chk("rst_mid_busy", busy, 0);
        #29 sys_rst_n = 1'b1;
        step();
        step();
        chk("post_rst_idle", bus.out_valid, 0);
        kick(2'd0, 32'd0, 32'h40, 32'h0);
        chk("restart_addr", bus.out_addr, 32'h40);
        chk("restart_cnt", beat_cnt, 0);
        chk("restart_valid", bus.out_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
